adder_operand_loader: RTL

Upstream stage of the 4-bit pad adder. Collects two 4-bit operands presented one after another on the user GPIO pads, each qualified by an asynchronous strobe pad. Presents them as a stable, registered pair to the combinational adder, with a one-cycle valid pulse, a pairing timeout and a completed-operation counter. Operands and counter are also mirrored to logic-analyzer probes by the top level.

---
 rtl/adder_operand_loader_pkg.sv | 14 +
 rtl/adder_operand_loader_if.sv | 26 ++
 rtl/adder_operand_loader_sync.sv | 45 ++++
 rtl/adder_operand_loader.sv | 136 +++++++++++++
 4 files changed

// File: rtl/adder_operand_loader_pkg.sv
// Shared types and constants for the pad adder operand loader.
package adder_io_pkg;

    localparam int DEF_W           = 4;
    localparam int DEF_TIMEOUT     = 255;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int CNT_W           = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_B = 1'b1
    } state_t;

endpackage

// File: rtl/adder_operand_loader_if.sv
// Pad-side operand inputs and adder-side registered outputs of the loader.
interface adder_operand_loader_if
    import adder_io_pkg::*;
#(
    parameter int W = DEF_W
);
    logic [W-1:0]     nib_i;
    logic             stb_i;
    logic             clr_i;
    logic [W-1:0]     a_o;
    logic [W-1:0]     b_o;
    logic             op_valid_o;
    logic             busy_o;
    logic             timeout_o;
    logic [CNT_W-1:0] op_cnt_o;

    modport master (
        output nib_i, stb_i, clr_i,
        input  a_o, b_o, op_valid_o, busy_o, timeout_o, op_cnt_o
    );

    modport slave (
        input  nib_i, stb_i, clr_i,
        output a_o, b_o, op_valid_o, busy_o, timeout_o, op_cnt_o
    );
endinterface

// File: rtl/adder_operand_loader_sync.sv
// Multi-flop synchronizer for asynchronous pad inputs with optional rising-edge detect.
module io_sync_edge #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               EDGE_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             rise
);
    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the pad value through the chain; stage 0 is the metastability catcher.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic [WIDTH-1:0] prev;

            // Previous value of the last stage, for rising-edge detection.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prev <= RST_VAL;
                end else begin
                    prev <= dout;
                end
            end

            assign rise = |(dout & ~prev);
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/adder_operand_loader.sv
// Collects two strobed pad nibbles into a registered operand pair for the adder.
module adder_operand_loader
    import adder_io_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n,
    adder_operand_loader_if.slave  bus
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic             stb_sync;
    logic             stb_edge;
    logic [W-1:0]     nib_sync;
    logic             nib_rise_unused;

    state_t           state, state_n;
    logic [TMR_W-1:0] tmr, tmr_n;
    logic [W-1:0]     a_pend, a_pend_n;
    logic [W-1:0]     a_hold, a_hold_n;
    logic [W-1:0]     b_hold, b_hold_n;
    logic             valid, valid_n;
    logic             tout, tout_n;
    logic             busy;
    logic [CNT_W-1:0] cnt, cnt_n;

    // Strobe resets high so a strobe held through reset is not seen as an edge.
    io_sync_edge #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1),
        .EDGE_EN (1'b1)
    ) u_stb_sync (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_n),
        .din  (bus.stb_i),
        .dout (stb_sync),
        .rise (stb_edge)
    );

    // Same depth as the strobe chain so the nibble lines up with the edge cycle.
    io_sync_edge #(
        .WIDTH   (W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ({W{1'b0}}),
        .EDGE_EN (1'b0)
    ) u_nib_sync (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_n),
        .din  (bus.nib_i),
        .dout (nib_sync),
        .rise (nib_rise_unused)
    );

    // Next-state and output decode; priority is clear, then edge, then timeout.
    always_comb begin
        state_n  = state;
        tmr_n    = tmr;
        a_pend_n = a_pend;
        a_hold_n = a_hold;
        b_hold_n = b_hold;
        valid_n  = 1'b0;
        tout_n   = 1'b0;
        cnt_n    = cnt;

        if (bus.clr_i) begin
            state_n  = IDLE;
            tmr_n    = '0;
            a_pend_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stb_edge) begin
                        a_pend_n = nib_sync;
                        tmr_n    = '0;
                        state_n  = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (stb_edge) begin
                        a_hold_n = a_pend;
                        b_hold_n = nib_sync;
                        valid_n  = 1'b1;
                        cnt_n    = cnt + 1'b1;
                        state_n  = IDLE;
                    end else if (tmr == TMR_LAST) begin
                        tout_n  = 1'b1;
                        tmr_n   = '0;
                        state_n = IDLE;
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, operand and status registers; everything returns to zero/IDLE on reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state  <= IDLE;
            tmr    <= '0;
            a_pend <= '0;
            a_hold <= '0;
            b_hold <= '0;
            valid  <= 1'b0;
            tout   <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            tmr    <= tmr_n;
            a_pend <= a_pend_n;
            a_hold <= a_hold_n;
            b_hold <= b_hold_n;
            valid  <= valid_n;
            tout   <= tout_n;
            busy   <= (state_n == WAIT_B);
            cnt    <= cnt_n;
        end
    end

    assign bus.a_o        = a_hold;
    assign bus.b_o        = b_hold;
    assign bus.op_valid_o = valid;
    assign bus.timeout_o  = tout;
    assign bus.busy_o     = busy;
    assign bus.op_cnt_o   = cnt;
endmodule
